// File: rtl/nnrv_exec_md.sv
// nnrv execute stage with RV32M: single-cycle ALU/jump/load/store, iterative MUL/DIV behind valid/ready.
// Optional macro NNRV_FAST_MUL_EN: MUL/MULH/MULHSU/MULHU become single-cycle combinational multiplies.
module nnrv_exec_md #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_id_valid,
   output logic                o_id_ready,
   input  logic [XLEN-1:0]     i_id_op1,
   input  logic [XLEN-1:0]     i_id_op2,
   input  logic [4:0]          i_id_exec_type,
   input  logic [XLEN/8-1:0]   i_id_ram_mask,
   input  logic                i_id_sign,
   input  logic [4:0]          i_id_rd,
   input  logic                i_id_rd_en,
   input  logic [XLEN-1:0]     i_id_pc,
   output logic                o_id_rd_en,
   output logic [4:0]          o_id_rd,
   output logic [XLEN-1:0]     o_id_rd_reg,
   output logic                o_id_rd_ready,
   output logic                o_mem_valid,
   output logic                o_mem_rd_en,
   output logic [4:0]          o_mem_rd,
   output logic [XLEN-1:0]     o_mem_rd_reg,
   output logic                o_mem_ram_wr_en,
   output logic                o_mem_ram_rd_en,
   output logic [XLEN-1:0]     o_mem_ram_addr,
   output logic [XLEN-1:0]     o_mem_ram_data,
   output logic [XLEN/8-1:0]   o_mem_ram_mask,
   output logic                o_mem_sign,
   output logic [1:0]          dbg_state
);

   localparam int LANES = XLEN / 8;
   localparam int LB    = $clog2(LANES);
   localparam int SB    = $clog2(XLEN);
   localparam logic [SB-1:0] CNT_LAST = SB'(XLEN - 1);

   localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_SLT = 5'd3,  OP_SLTU = 5'd4;
   localparam logic [4:0] OP_XOR = 5'd5,  OP_OR  = 5'd6,  OP_AND = 5'd7,  OP_SLL  = 5'd8;
   localparam logic [4:0] OP_SRL = 5'd9,  OP_SRA = 5'd10, OP_JMP = 5'd11, OP_LOAD = 5'd12;
   localparam logic [4:0] OP_STORE = 5'd13, OP_MUL = 5'd14, OP_MULH = 5'd15, OP_MULHSU = 5'd16;
   localparam logic [4:0] OP_MULHU = 5'd17, OP_DIV = 5'd18, OP_DIVU = 5'd19, OP_REM = 5'd20;
   localparam logic [4:0] OP_REMU = 5'd21;

   if (ADDR_WIDTH < 1 || ADDR_WIDTH > XLEN || XLEN < 32 || (XLEN & (XLEN - 1)) != 0) begin : g_param_check
      $error("nnrv_exec_md: unsupported XLEN/ADDR_WIDTH combination");
   end

   // valid/ready: an op transfers on a cycle where i_id_valid & o_id_ready; ready is high only in IDLE.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

   state_t state_q, state_d;

   logic                accept, is_mul_op, is_div_op, go_mul, go_div, is_known, is_mem;
   logic                s1, s2, n1, n2;
   logic [XLEN-1:0]     a_abs, b_abs, alu_res, byte_mask, store_data, md_res;
   logic [LANES-1:0]    lane_mask;
   logic [SB-1:0]       shamt;
   logic [2*XLEN-1:0]   fast_prod;

   logic [4:0]          op_q;
   logic [XLEN-1:0]     op1_q, mcand_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [SB-1:0]       cnt_q;
   logic                neg_q, rneg_q, dz_q, ovf_q;

   logic                rd_en_q, rd_ready_q, valid_q, wr_q, rdreq_q, sign_q;
   logic [4:0]          rd_q;
   logic [XLEN-1:0]     rd_reg_q, addr_q, data_q;
   logic [LANES-1:0]    mask_q;

   assign o_id_ready = (state_q == S_IDLE);
   assign accept     = i_id_valid & o_id_ready;
   assign dbg_state  = state_q;

   assign is_mul_op = (i_id_exec_type >= OP_MUL) && (i_id_exec_type <= OP_MULHU);
   assign is_div_op = (i_id_exec_type >= OP_DIV) && (i_id_exec_type <= OP_REMU);
   assign is_known  = (i_id_exec_type >= OP_ADD) && (i_id_exec_type <= OP_REMU);
   assign is_mem    = (i_id_exec_type == OP_LOAD) || (i_id_exec_type == OP_STORE);
   assign go_div    = is_div_op;

   assign s1    = i_id_exec_type inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   assign s2    = i_id_exec_type inside {OP_MULH, OP_DIV, OP_REM};
   assign n1    = s1 & i_id_op1[XLEN-1];
   assign n2    = s2 & i_id_op2[XLEN-1];
   assign a_abs = n1 ? -i_id_op1 : i_id_op1;
   assign b_abs = n2 ? -i_id_op2 : i_id_op2;

`ifdef NNRV_FAST_MUL_EN
   // Sign-extending both operands to 2*XLEN makes one multiplier serve all four variants.
   logic [2*XLEN-1:0] ext1, ext2;
   assign ext1      = {{XLEN{n1}}, i_id_op1};
   assign ext2      = {{XLEN{n2}}, i_id_op2};
   assign fast_prod = ext1 * ext2;
   assign go_mul    = 1'b0;
`else
   assign fast_prod = '0;
   assign go_mul    = is_mul_op;
`endif

   assign shamt     = i_id_op2[SB-1:0];
   assign lane_mask = i_id_ram_mask << i_id_op2[LB-1:0];

   always_comb begin
      byte_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         byte_mask[8*i +: 8] = {8{i_id_ram_mask[i]}};
      end
   end

   assign store_data = (i_id_op1 & byte_mask) << {i_id_op2[LB-1:0], 3'b000};

   always_comb begin
      alu_res = '0;
      case (i_id_exec_type)
         OP_ADD:    alu_res = i_id_op1 + i_id_op2;
         OP_SUB:    alu_res = i_id_op1 - i_id_op2;
         OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(i_id_op1) < $signed(i_id_op2)};
         OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, i_id_op1 < i_id_op2};
         OP_XOR:    alu_res = i_id_op1 ^ i_id_op2;
         OP_OR:     alu_res = i_id_op1 | i_id_op2;
         OP_AND:    alu_res = i_id_op1 & i_id_op2;
         OP_SLL:    alu_res = i_id_op1 << shamt;
         OP_SRL:    alu_res = i_id_op1 >> shamt;
         OP_SRA:    alu_res = $unsigned($signed(i_id_op1) >>> shamt);
         OP_JMP:    alu_res = i_id_pc + XLEN'(4);
         OP_MUL:    alu_res = fast_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: alu_res = fast_prod[2*XLEN-1:XLEN];
         default:   alu_res = '0;
      endcase
   end

   // Multiply: low half of acc holds the multiplier and shifts out one bit per step.
   logic [XLEN:0]     mul_sum, div_trial;
   logic [2*XLEN-1:0] mul_next, div_next, prod;
   logic [XLEN-1:0]   quo, rem;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   // Restoring divide: acc = {remainder, dividend/quotient}; the trial sign decides the quotient bit.
   assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
   assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign prod = neg_q ? -acc_q : acc_q;

   always_comb begin
      quo = neg_q  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
      rem = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (dz_q) begin
         quo = '1;
         rem = op1_q;
      end else if (ovf_q) begin
         quo = op1_q;
         rem = '0;
      end
   end

   always_comb begin
      md_res = '0;
      case (op_q)
         OP_MUL:                       md_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              md_res = quo;
         OP_REM, OP_REMU:              md_res = rem;
         default:                      md_res = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && go_mul)      state_d = S_MUL;
                  else if (accept && go_div) state_d = S_DIV;
         S_MUL:   if (cnt_q == CNT_LAST)     state_d = S_DONE;
         S_DIV:   if (cnt_q == CNT_LAST)     state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         op_q <= '0; op1_q <= '0; mcand_q <= '0; acc_q <= '0; cnt_q <= '0;
         neg_q <= 1'b0; rneg_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
         rd_en_q <= 1'b0; rd_q <= '0; rd_reg_q <= '0; rd_ready_q <= 1'b0;
         valid_q <= 1'b0; wr_q <= 1'b0; rdreq_q <= 1'b0; sign_q <= 1'b0;
         addr_q <= '0; data_q <= '0; mask_q <= '0;
      end else begin
         valid_q <= 1'b0;
         wr_q    <= 1'b0;
         rdreq_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  rd_q <= i_id_rd;
                  if (go_mul || go_div) begin
                     rd_en_q    <= i_id_rd_en;
                     rd_reg_q   <= '0;
                     rd_ready_q <= 1'b0;
                     addr_q     <= '0;
                     data_q     <= '0;
                     mask_q     <= '0;
                     sign_q     <= 1'b0;
                     op_q       <= i_id_exec_type;
                     op1_q      <= i_id_op1;
                     mcand_q    <= b_abs;
                     acc_q      <= {{XLEN{1'b0}}, a_abs};
                     cnt_q      <= '0;
                     neg_q      <= n1 ^ n2;
                     rneg_q     <= n1;
                     dz_q       <= (i_id_op2 == '0);
                     ovf_q      <= s1 & s2 & (i_id_op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_id_op2);
                  end else begin
                     valid_q    <= 1'b1;
                     rd_en_q    <= is_known & i_id_rd_en;
                     rd_reg_q   <= alu_res;
                     rd_ready_q <= is_known & ~is_mem;
                     wr_q       <= (i_id_exec_type == OP_STORE);
                     rdreq_q    <= (i_id_exec_type == OP_LOAD);
                     sign_q     <= (i_id_exec_type == OP_LOAD) & i_id_sign;
                     addr_q     <= is_mem ? i_id_op2 : '0;
                     mask_q     <= is_mem ? lane_mask : '0;
                     data_q     <= (i_id_exec_type == OP_STORE) ? store_data : '0;
                  end
               end
            end
            S_MUL: begin
               acc_q <= mul_next;
               cnt_q <= cnt_q + SB'(1);
            end
            S_DIV: begin
               acc_q <= div_next;
               cnt_q <= cnt_q + SB'(1);
            end
            S_DONE: begin
               valid_q    <= 1'b1;
               rd_reg_q   <= md_res;
               rd_ready_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_id_rd_en      = rd_en_q;
   assign o_id_rd         = rd_q;
   assign o_id_rd_reg     = rd_reg_q;
   assign o_id_rd_ready   = rd_ready_q;
   assign o_mem_valid     = valid_q;
   assign o_mem_rd_en     = rd_en_q;
   assign o_mem_rd        = rd_q;
   assign o_mem_rd_reg    = rd_reg_q;
   assign o_mem_ram_wr_en = wr_q;
   assign o_mem_ram_rd_en = rdreq_q;
   assign o_mem_ram_addr  = addr_q;
   assign o_mem_ram_data  = data_q;
   assign o_mem_ram_mask  = mask_q;
   assign o_mem_sign      = sign_q;

endmodule

// File: tb/tb_nnrv_exec_md.sv
// Directed bench for nnrv_exec_md (default build, iterative MUL/DIV, XLEN=32).
module tb_nnrv_exec_md;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_id_valid = 1'b0;
   logic        o_id_ready;
   logic [31:0] i_id_op1 = '0, i_id_op2 = '0, i_id_pc = '0;
   logic [4:0]  i_id_exec_type = '0;
   logic [3:0]  i_id_ram_mask = '0;
   logic        i_id_sign = 1'b0;
   logic [4:0]  i_id_rd = '0;
   logic        i_id_rd_en = 1'b0;
   logic        o_id_rd_en, o_id_rd_ready, o_mem_valid, o_mem_rd_en;
   logic [4:0]  o_id_rd, o_mem_rd;
   logic [31:0] o_id_rd_reg, o_mem_rd_reg, o_mem_ram_addr, o_mem_ram_data;
   logic        o_mem_ram_wr_en, o_mem_ram_rd_en, o_mem_sign;
   logic [3:0]  o_mem_ram_mask;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   nnrv_exec_md #(.XLEN(32), .ADDR_WIDTH(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
      .i_id_op1(i_id_op1), .i_id_op2(i_id_op2), .i_id_exec_type(i_id_exec_type),
      .i_id_ram_mask(i_id_ram_mask), .i_id_sign(i_id_sign), .i_id_rd(i_id_rd),
      .i_id_rd_en(i_id_rd_en), .i_id_pc(i_id_pc), .o_id_rd_en(o_id_rd_en), .o_id_rd(o_id_rd),
      .o_id_rd_reg(o_id_rd_reg), .o_id_rd_ready(o_id_rd_ready), .o_mem_valid(o_mem_valid),
      .o_mem_rd_en(o_mem_rd_en), .o_mem_rd(o_mem_rd), .o_mem_rd_reg(o_mem_rd_reg),
      .o_mem_ram_wr_en(o_mem_ram_wr_en), .o_mem_ram_rd_en(o_mem_ram_rd_en),
      .o_mem_ram_addr(o_mem_ram_addr), .o_mem_ram_data(o_mem_ram_data),
      .o_mem_ram_mask(o_mem_ram_mask), .o_mem_sign(o_mem_sign), .dbg_state(dbg_state)
   );

   always #5 i_clk = ~i_clk;

   // Drives one op for exactly one accepting edge, returns 1 time unit after that edge.
   task automatic issue(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] mask, input logic sgn, input logic [4:0] rd,
                        input logic rd_en, input logic [31:0] pc);
      @(negedge i_clk);
      i_id_exec_type = t; i_id_op1 = a; i_id_op2 = b; i_id_ram_mask = mask;
      i_id_sign = sgn; i_id_rd = rd; i_id_rd_en = rd_en; i_id_pc = pc; i_id_valid = 1'b1;
      @(posedge i_clk); #1;
      i_id_valid = 1'b0;
   endtask

   // Issues an MD op, scrambles inputs while busy, waits (bounded) for the retire pulse.
   task automatic run_md(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int low_cycles, output bit timed_out,
                         output bit fwd_bad);
      issue(t, a, b, 4'h0, 1'b0, 5'd11, 1'b1, 32'h0);
      i_id_op1 = 32'hDEAD_BEEF; i_id_op2 = 32'h0000_1234; i_id_exec_type = 5'd1; i_id_rd = 5'd3;
      low_cycles = 0; timed_out = 1'b1; fwd_bad = 1'b0; res = '0;
      for (int i = 0; i < 100; i++) begin
         if (o_mem_valid) begin
            timed_out = 1'b0;
            break;
         end
         if (!o_id_ready) low_cycles++;
         if (o_id_rd_ready || o_id_rd !== 5'd11 || !o_id_rd_en) fwd_bad = 1'b1;
         @(posedge i_clk); #1;
      end
      res = o_mem_rd_reg;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge i_clk);
      #1;
      checks++; if (o_mem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_mem_valid); end
      checks++; if (o_id_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_id_ready); end
      checks++; if ({o_id_rd_reg, o_mem_ram_data, o_mem_ram_addr} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", o_id_rd_reg, o_mem_ram_data, o_mem_ram_addr); end
      checks++; if ({o_id_rd_ready, o_id_rd_en, o_mem_ram_wr_en, o_mem_ram_rd_en, o_mem_ram_mask, o_id_rd} !== 13'h0) begin failures++; $display("FAIL reset_ctrl got=%b%b%b%b %b %h exp=0", o_id_rd_ready, o_id_rd_en, o_mem_ram_wr_en, o_mem_ram_rd_en, o_mem_ram_mask, o_id_rd); end
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      issue(5'd1, 32'd7, 32'hFFFF_FFFD, 4'h0, 1'b0, 5'd5, 1'b1, 32'h0);
      checks++; if (o_mem_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", o_mem_valid); end
      checks++; if (o_mem_rd_reg !== 32'd4) begin failures++; $display("FAIL add_res got=%h exp=00000004", o_mem_rd_reg); end
      checks++; if (o_id_rd_reg !== 32'd4 || o_id_rd !== 5'd5 || o_id_rd_en !== 1'b1 || o_id_rd_ready !== 1'b1) begin failures++; $display("FAIL add_fwd got=%h rd=%0d en=%b rdy=%b exp=4/5/1/1", o_id_rd_reg, o_id_rd, o_id_rd_en, o_id_rd_ready); end
      issue(5'd10, 32'h8000_0000, 32'd35, 4'h0, 1'b0, 5'd6, 1'b1, 32'h0);
      checks++; if (o_mem_valid !== 1'b1) begin failures++; $display("FAIL sra_consecutive_valid got=%b exp=1", o_mem_valid); end
      checks++; if (o_mem_rd_reg !== 32'hF000_0000) begin failures++; $display("FAIL sra_masked got=%h exp=f0000000", o_mem_rd_reg); end
      @(posedge i_clk); #1;
      checks++; if (o_mem_valid !== 1'b0) begin failures++; $display("FAIL idle_no_valid got=%b exp=0", o_mem_valid); end
   endtask

   task automatic test_alu;
      issue(5'd2, 32'd5, 32'd7, 4'h0, 1'b0, 5'd1, 1'b1, 32'h0);
      checks++; if (o_mem_rd_reg !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub got=%h exp=fffffffe", o_mem_rd_reg); end
      issue(5'd3, 32'hFFFF_FFFF, 32'd1, 4'h0, 1'b0, 5'd1, 1'b1, 32'h0);
      checks++; if (o_mem_rd_reg !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=00000001", o_mem_rd_reg); end
      issue(5'd4, 32'hFFFF_FFFF, 32'd1, 4'h0, 1'b0, 5'd1, 1'b1, 32'h0);
      checks++; if (o_mem_rd_reg !== 32'd0) begin failures++; $display("FAIL sltu got=%h exp=00000000", o_mem_rd_reg); end
      issue(5'd5, 32'h0000_F0F0, 32'h0000_FF00, 4'h0, 1'b0, 5'd1, 1'b1, 32'h0);
      checks++; if (o_mem_rd_reg !== 32'h0000_0FF0) begin failures++; $display("FAIL xor got=%h exp=00000ff0", o_mem_rd_reg); end
      issue(5'd8, 32'd1, 32'd33, 4'h0, 1'b0, 5'd1, 1'b1, 32'h0);
      checks++; if (o_mem_rd_reg !== 32'd2) begin failures++; $display("FAIL sll_masked got=%h exp=00000002", o_mem_rd_reg); end
      issue(5'd9, 32'h8000_0000, 32'd4, 4'h0, 1'b0, 5'd1, 1'b1, 32'h0);
      checks++; if (o_mem_rd_reg !== 32'h0800_0000) begin failures++; $display("FAIL srl got=%h exp=08000000", o_mem_rd_reg); end
      issue(5'd11, 32'd0, 32'd0, 4'h0, 1'b0, 5'd1, 1'b1, 32'h0000_0100);
      checks++; if (o_mem_rd_reg !== 32'h0000_0104) begin failures++; $display("FAIL jmp got=%h exp=00000104", o_mem_rd_reg); end
      issue(5'd0, 32'd9, 32'd9, 4'h0, 1'b0, 5'd2, 1'b1, 32'h0);
      checks++; if (o_mem_valid !== 1'b1 || o_mem_rd_en !== 1'b0 || o_mem_rd_reg !== 32'd0 || o_mem_ram_wr_en !== 1'b0 || o_mem_ram_rd_en !== 1'b0) begin failures++; $display("FAIL nop got v=%b en=%b res=%h wr=%b rd=%b exp=1/0/0/0/0", o_mem_valid, o_mem_rd_en, o_mem_rd_reg, o_mem_ram_wr_en, o_mem_ram_rd_en); end
   endtask

   task automatic test_mem;
      issue(5'd13, 32'h0000_00AB, 32'h0000_0013, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h0);
      checks++; if (o_mem_valid !== 1'b1 || o_mem_ram_wr_en !== 1'b1 || o_mem_ram_rd_en !== 1'b0) begin failures++; $display("FAIL store_ctrl got v=%b wr=%b rd=%b exp=1/1/0", o_mem_valid, o_mem_ram_wr_en, o_mem_ram_rd_en); end
      checks++; if (o_mem_ram_data !== 32'hAB00_0000) begin failures++; $display("FAIL store_data got=%h exp=ab000000", o_mem_ram_data); end
      checks++; if (o_mem_ram_mask !== 4'b1000 || o_mem_ram_addr !== 32'h13) begin failures++; $display("FAIL store_lane got mask=%b addr=%h exp=1000/13", o_mem_ram_mask, o_mem_ram_addr); end
      checks++; if (o_id_rd_ready !== 1'b0) begin failures++; $display("FAIL store_rd_ready got=%b exp=0", o_id_rd_ready); end
      @(posedge i_clk); #1;
      checks++; if (o_mem_ram_wr_en !== 1'b0 || o_mem_valid !== 1'b0) begin failures++; $display("FAIL store_deassert got wr=%b v=%b exp=0/0", o_mem_ram_wr_en, o_mem_valid); end
      issue(5'd12, 32'h0, 32'h0000_0022, 4'b0011, 1'b1, 5'd9, 1'b1, 32'h0);
      checks++; if (o_mem_ram_rd_en !== 1'b1 || o_mem_ram_wr_en !== 1'b0 || o_mem_rd_en !== 1'b1 || o_mem_rd !== 5'd9) begin failures++; $display("FAIL load_ctrl got rd=%b wr=%b en=%b rd=%0d exp=1/0/1/9", o_mem_ram_rd_en, o_mem_ram_wr_en, o_mem_rd_en, o_mem_rd); end
      checks++; if (o_id_rd_ready !== 1'b0 || o_mem_ram_mask !== 4'b1100 || o_mem_sign !== 1'b1) begin failures++; $display("FAIL load_misc got rdy=%b mask=%b sign=%b exp=0/1100/1", o_id_rd_ready, o_mem_ram_mask, o_mem_sign); end
   endtask

   task automatic test_muldiv;
      logic [4:0]  ops[8]  = '{5'd14, 5'd17, 5'd15, 5'd18, 5'd20, 5'd19, 5'd20, 5'd21};
      logic [31:0] as[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd5};
      logic [31:0] bs[8]   = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] exps[8] = '{32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd5};
      logic [31:0] res;
      int          low;
      bit          tmo, fwd_bad;
      for (int k = 0; k < 8; k++) begin
         run_md(ops[k], as[k], bs[k], res, low, tmo, fwd_bad);
         checks++; if (tmo) begin failures++; $display("FAIL md%0d_timeout got=no_valid exp=valid", k); end
         checks++; if (res !== exps[k]) begin failures++; $display("FAIL md%0d_res got=%h exp=%h", k, res, exps[k]); end
         checks++; if (low != 33) begin failures++; $display("FAIL md%0d_ready_low got=%0d exp=33", k, low); end
         checks++; if (fwd_bad || o_id_rd_ready !== 1'b1 || o_id_ready !== 1'b1) begin failures++; $display("FAIL md%0d_fwd got bad=%b rdy=%b ready=%b exp=0/1/1", k, fwd_bad, o_id_rd_ready, o_id_ready); end
         @(posedge i_clk); #1;
         checks++; if (o_mem_valid !== 1'b0) begin failures++; $display("FAIL md%0d_single_pulse got=%b exp=0", k, o_mem_valid); end
      end
   endtask

   task automatic test_reset_mid_div;
      int pulses = 0;
      issue(5'd18, 32'd100, 32'd7, 4'h0, 1'b0, 5'd4, 1'b1, 32'h0);
      repeat (9) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      checks++; if (o_mem_valid !== 1'b0 || o_id_ready !== 1'b1 || dbg_state !== 2'd0) begin failures++; $display("FAIL abort_state got v=%b ready=%b st=%0d exp=0/1/0", o_mem_valid, o_id_ready, dbg_state); end
      checks++; if (o_id_rd_reg !== 32'h0 || o_id_rd !== 5'd0 || o_id_rd_en !== 1'b0 || o_id_rd_ready !== 1'b0) begin failures++; $display("FAIL abort_outputs got %h/%0d/%b/%b exp=0", o_id_rd_reg, o_id_rd, o_id_rd_en, o_id_rd_ready); end
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk); #1;
         if (o_mem_valid) pulses++;
      end
      checks++; if (pulses != 0) begin failures++; $display("FAIL abort_no_pulse got=%0d exp=0", pulses); end
      issue(5'd1, 32'd2, 32'd3, 4'h0, 1'b0, 5'd8, 1'b1, 32'h0);
      checks++; if (o_mem_valid !== 1'b1 || o_mem_rd_reg !== 32'd5) begin failures++; $display("FAIL post_reset_add got v=%b res=%h exp=1/00000005", o_mem_valid, o_mem_rd_reg); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_alu();
      test_mem();
      test_muldiv();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
